// File: rtl/uart_pkg.sv
// Shared UART constants: frame geometry, baud divisors for a 50 MHz clock,
// line levels and the transmit engine state encoding.
package uart_pkg;

  localparam int BAUD_W     = 20;
  localparam int FRAME_BITS = 11;

  localparam int K_9600   = 5208;
  localparam int K_19200  = 2604;
  localparam int K_115200 = 434;

  localparam logic STOP_BIT  = 1'b1;
  localparam logic START_BIT = 1'b0;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_LOAD  = 2'd1,
    TX_SHIFT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time generator: counts k clocks per bit and FRAME_BITS bits per frame,
// flagging each bit boundary (btu) and the final one (done).
module uart_bit_timer #(
  parameter int BAUD_W     = 20,
  parameter int FRAME_BITS = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              doit_i,
  input  logic [BAUD_W-1:0] k_i,
  output logic              btu_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(FRAME_BITS);

  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  // k_i is never zero: the engine clamps it to 1 when latching.
  assign btu_o  = doit_i && (baud_cnt_q == (k_i - 1'b1));
  assign done_o = btu_o && (bit_cnt_q == CNT_W'(FRAME_BITS - 1));

  always_comb begin
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!doit_i) begin
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (btu_o) begin
      baud_cnt_d = '0;
      bit_cnt_d  = done_o ? '0 : bit_cnt_q + 1'b1;
    end else begin
      baud_cnt_d = baud_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit framing: one-byte holding register, framing-bit capture from
// the bit decoder, and an LSB-first 11-bit shift register driving tx.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int BAUD_W = uart_pkg::BAUD_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [7:0]        out_port,
  input  logic [BAUD_W-1:0] baud_k,
  input  logic              b10,
  input  logic              b9,
  output logic [7:0]        ld_data,
  output logic              tx,
  output logic              txrdy,
  output logic              tx_done
);

  tx_state_e                 state_q, state_d;
  logic [7:0]                ld_data_q, ld_data_d;
  logic [FRAME_BITS-1:0]     shift_q, shift_d;
  logic [BAUD_W-1:0]         k_q, k_d;
  logic                      tx_done_q, tx_done_d;
  logic                      doit, btu, done;

  // Handshake: a byte is taken on any edge where load=1 and txrdy=1; txrdy
  // stays low from that edge until the stop bit finishes, and load while
  // txrdy=0 is dropped, not queued.
  assign txrdy   = (state_q == TX_IDLE);
  assign doit    = (state_q == TX_SHIFT);
  assign ld_data = ld_data_q;
  assign tx      = shift_q[0];
  assign tx_done = tx_done_q;

  uart_bit_timer #(
    .BAUD_W    (BAUD_W),
    .FRAME_BITS(FRAME_BITS)
  ) u_bit_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .doit_i (doit),
    .k_i    (k_q),
    .btu_o  (btu),
    .done_o (done)
  );

  always_comb begin
    state_d   = state_q;
    ld_data_d = ld_data_q;
    shift_d   = shift_q;
    k_d       = k_q;
    tx_done_d = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (load) begin
          ld_data_d = out_port;
          state_d   = TX_LOAD;
        end
      end
      // One cycle after capture the decoder's b10/b9 reflect the new byte.
      TX_LOAD: begin
        shift_d = {STOP_BIT, b10, b9, ld_data_q[6:0], START_BIT};
        k_d     = (baud_k == '0) ? BAUD_W'(1) : baud_k;
        state_d = TX_SHIFT;
      end
      TX_SHIFT: begin
        if (btu) begin
          shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
          if (done) begin
            state_d   = TX_IDLE;
            tx_done_d = 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= TX_IDLE;
      ld_data_q <= 8'h00;
      shift_q   <= '1;
      k_q       <= BAUD_W'(1);
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_data_q <= ld_data_d;
      shift_q   <= shift_d;
      k_q       <= k_d;
      tx_done_q <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed and randomized checks of uart_tx_engine against a frame-level
// model: each frame is an 11-entry bit list, each bit held for k clocks.
module tb_uart_tx_engine;
  import uart_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              load;
  logic [7:0]        out_port;
  logic [BAUD_W-1:0] baud_k;
  logic              b10, b9;
  logic [7:0]        ld_data;
  logic              tx, txrdy, tx_done;

  int   n_cmp = 0;
  int   n_err = 0;
  int   mode  = 0;  // 0: 8N1 (b9=d7), 1: 7E1 (b9=even parity), 2: fixed bits
  logic fix9  = 1'b0;
  logic fix10 = 1'b1;

  always #5 clk = ~clk;

  // Bit decoder stand-in, fed from the holding register like the real one.
  assign b9  = (mode == 0) ? ld_data[7] : (mode == 1) ? ^ld_data[6:0] : fix9;
  assign b10 = (mode < 2) ? 1'b1 : fix10;

  uart_tx_engine #(.BAUD_W(BAUD_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .out_port(out_port),
    .baud_k  (baud_k),
    .b10     (b10),
    .b9      (b9),
    .ld_data (ld_data),
    .tx      (tx),
    .txrdy   (txrdy),
    .tx_done (tx_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] model_frame(input logic [7:0] d, input int m,
                                              input logic f9, input logic f10);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 7; i++) f[i+1] = d[i];
    f[8]  = (m == 0) ? d[7] : (m == 1) ? ^d[6:0] : f9;
    f[9]  = (m < 2) ? 1'b1 : f10;
    f[10] = 1'b1;
    return f;
  endfunction

  // Sends byte b and checks every cycle of the frame. inj_at: cycle index
  // (from the start bit) at which a stray load of inj_b is pulsed; abort_at:
  // cycle at which reset is asserted; chg_at: cycle at which baud_k becomes chg_k.
  task automatic send(input logic [7:0] b, input int k_eff, input int inj_at,
                      input logic [7:0] inj_b, input int abort_at,
                      input int chg_at, input int chg_k);
    logic [10:0] f;
    int waited;
    waited = 0;
    while (txrdy !== 1'b1 && waited < 500) begin
      tick();
      waited++;
    end
    check("ready_wait", {31'd0, txrdy}, 32'd1);
    f = model_frame(b, mode, fix9, fix10);
    load = 1'b1;
    out_port = b;
    tick();
    load = 1'b0;
    out_port = 8'($urandom);
    check("accept_txrdy", {31'd0, txrdy}, 32'd0);
    check("accept_ld", {24'd0, ld_data}, {24'd0, b});
    check("accept_tx_idle", {31'd0, tx}, 32'd1);
    check("accept_done", {31'd0, tx_done}, 32'd0);
    tick();
    for (int c = 0; c < 11 * k_eff; c++) begin
      if (c == abort_at) begin
        reset_n = 1'b0;
        tick();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_txrdy", {31'd0, txrdy}, 32'd1);
        check("rst_done", {31'd0, tx_done}, 32'd0);
        check("rst_ld", {24'd0, ld_data}, 32'd0);
        reset_n = 1'b1;
        return;
      end
      check("frame_tx", {31'd0, tx}, {31'd0, f[c / k_eff]});
      check("frame_txrdy", {31'd0, txrdy}, 32'd0);
      check("frame_done", {31'd0, tx_done}, 32'd0);
      check("frame_ld", {24'd0, ld_data}, {24'd0, b});
      if (c == chg_at) baud_k = BAUD_W'(chg_k);
      if (c == inj_at) begin
        load = 1'b1;
        out_port = inj_b;
      end
      tick();
      load = 1'b0;
    end
    check("end_done", {31'd0, tx_done}, 32'd1);
    check("end_txrdy", {31'd0, txrdy}, 32'd1);
    check("end_tx", {31'd0, tx}, 32'd1);
    check("end_ld", {24'd0, ld_data}, {24'd0, b});
  endtask

  initial begin
    int kb;
    logic [7:0] rb;

    // Reset, with a load attempted while reset is held.
    reset_n = 1'b0;
    load = 1'b0;
    out_port = 8'h00;
    baud_k = BAUD_W'(4);
    tick();
    load = 1'b1;
    out_port = 8'h5A;
    tick();
    load = 1'b0;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_txrdy", {31'd0, txrdy}, 32'd1);
    check("reset_done", {31'd0, tx_done}, 32'd0);
    check("reset_ld", {24'd0, ld_data}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("post_reset_idle", {31'd0, tx}, 32'd1);

    // 8N1 and 7E1 frames.
    mode = 0;
    send(8'hA5, 4, -1, 8'h00, -1, -1, 0);
    mode = 1;
    send(8'h41, 4, -1, 8'h00, -1, -1, 0);

    // Stray load mid-frame and at the frame-end edge are both dropped.
    mode = 0;
    send(8'h12, 4, 17, 8'h34, -1, -1, 0);
    send(8'h12, 4, 43, 8'h34, -1, -1, 0);
    tick();
    check("no_late_accept", {31'd0, txrdy}, 32'd1);
    check("done_one_cycle", {31'd0, tx_done}, 32'd0);
    // Load in the tx_done cycle is accepted; gap checked inside send.
    send(8'h12, 4, -1, 8'h00, -1, -1, 0);
    send(8'h34, 4, -1, 8'h00, -1, -1, 0);

    // Reset during bit 5, then a full fresh frame.
    send(8'hC3, 4, -1, 8'h00, 5 * 4 + 1, -1, 0);
    send(8'h3C, 4, -1, 8'h00, -1, -1, 0);

    // baud_k of 0 and 1 both give 1-clock bits; mid-frame change is deferred.
    baud_k = '0;
    send(8'hFF, 1, -1, 8'h00, -1, -1, 0);
    baud_k = BAUD_W'(1);
    send(8'hFF, 1, -1, 8'h00, -1, 3, 8);
    send(8'h96, 8, -1, 8'h00, -1, -1, 0);

    // Randomized frames.
    for (int i = 0; i < 10; i++) begin
      mode  = int'($urandom_range(0, 2));
      fix9  = 1'($urandom);
      fix10 = 1'($urandom);
      kb    = int'($urandom_range(0, 6));
      rb    = 8'($urandom);
      baud_k = BAUD_W'(kb);
      send(rb, (kb == 0) ? 1 : kb, -1, 8'h00, -1, -1, 0);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
    end

    // Back-to-back frames at a real divisor.
    mode = 0;
    baud_k = BAUD_W'(K_115200);
    send(8'h00, K_115200, -1, 8'h00, -1, -1, 0);
    send(8'h80, K_115200, -1, 8'h00, -1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
